rx_frame_parser: RTL and testbench
==================================

# rx_frame_parser

Receive-side frame parser sitting directly downstream of the MII receive byte assembler in each switch port. It consumes assembled receive bytes and the frame-active level, strips preamble/SFD, and extracts destination MAC, source MAC, EtherType and total frame length. The result goes to the switch core through a valid/ready handshake. Malformed, oversized and (optionally) runt frames are dropped and counted.

## Interface
Parameters:
- MIN_FRAME_BYTES, 64, minimum legal length (dest MAC through FCS)
- MAX_FRAME_BYTES, 1518, maximum legal length; longer frames are dropped

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- in_data  input  8  assembled byte; first MII nibble in [7:4], second in [3:0]
- in_valid  input  1  one-cycle strobe, in_data valid
- in_frame  input  1  frame-active level (synchronised RX_DV)
- out_valid  output  1  header/length result available
- out_ready  input  1  switch core accepts result
- out_destin_mac  output  48  destination MAC, first wire byte in [47:40]
- out_source_mac  output  48  source MAC, first wire byte in [47:40]
- out_ethertype  output  16  EtherType/length field, first wire byte in [15:8]
- out_length  output  16  byte count from first dest byte through FCS
- drop_count  output  16  dropped-frame counter, saturating

## Operation
- Byte correction: every accepted byte is nibble-swapped, b = {in_data[3:0], in_data[7:4]}. The preamble byte appears as 8'h55 and the SFD as 8'h5D on in_data before the swap.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, REPORT, DISCARD.
- IDLE: in_frame=1 -> PREAMBLE. in_valid is ignored while in IDLE.
- PREAMBLE: in_data 8'h55 -> stay. 8'h5D -> HEADER with count cleared. Any other byte -> DISCARD with drop++. in_frame=0 -> IDLE with no drop (carrier noise).
- HEADER: count increments per byte. Bytes 0-5 shift into destin, 6-11 into source, 12-13 into ethertype. After byte 13 -> PAYLOAD. in_frame=0 -> IDLE with drop++.
- PAYLOAD: count increments per byte. If count would exceed MAX_FRAME_BYTES -> DISCARD with drop++. in_frame=0 -> REPORT with out_length=count.
- REPORT: out_valid=1 and all out_* held stable until out_ready=1. On handshake: in_frame=0 -> IDLE. in_frame=1 -> DISCARD with drop++, because a new frame started while the result was pending.
- DISCARD: in_frame=0 -> IDLE. Bytes are ignored.
- in_valid and in_frame=0 in the same cycle: the byte is counted/captured first, then the end of frame is taken.
- drop_count saturates at 16'hFFFF.
- Length arithmetic: 16-bit counter, compared against parameters unsigned.

## Timing
- Reset values: out_valid=0, all out_* fields=0, drop_count=0, state=IDLE.
- Reset mid-frame returns to IDLE immediately. The partial frame is not counted.
- out_valid rises on the clock edge after the cycle where in_frame=0 is sampled in PAYLOAD (1-cycle latency).
- Handshake: the transfer occurs on the edge where out_valid=1 and out_ready=1. out_valid is 0 the next cycle.
- out_ready=1 held permanently gives out_valid one-cycle pulses.
- out_ready has no effect outside REPORT.
- drop_count updates on the edge the drop decision is made.

## Configuration
- RX_FRAME_PARSER_RUNT_FILTER_EN defined: on the PAYLOAD->REPORT transition, count < MIN_FRAME_BYTES goes instead to IDLE with drop++ and no out_valid.
- Undefined: runt frames of 14 bytes or more are reported normally. Frames ending in HEADER are always dropped.

## Test plan
- 7x 8'h55, 8'h5D, then a 64-byte frame (dest FF:FF:FF:FF:FF:FF, src 11:22:33:44:55:66, type 0800; fed nibble-swapped), then in_frame low, out_ready=1 -> one out_valid pulse 1 cycle after end, out_length=64, ethertype=16'h0800, destin=48'hFFFFFFFFFFFF, source=48'h112233445566, drop_count=0.
- Same frame with out_ready=0 for 10 cycles, then 1 -> out_valid held 10+ cycles, fields stable, cleared the cycle after handshake.
- Preamble with byte 8'hAA before SFD -> no out_valid, drop_count=1.
- 1519-byte frame -> no out_valid, drop_count=1. A following 1518-byte frame -> out_length=1518.
- 40-byte frame: with the macro -> drop_count=1, no out_valid. Without the macro -> out_valid, out_length=40. A 10-byte frame -> dropped in both builds.
- Assert reset mid-PAYLOAD -> outputs 0 immediately. The next valid frame parses correctly and drop_count stays 0.

Source files
------------

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: strips preamble/SFD, extracts MACs, EtherType and length.
// Optional runt drop: define RX_FRAME_PARSER_RUNT_FILTER_EN.
module rx_frame_parser #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_frame,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_destin_mac,
  output logic [47:0] out_source_mac,
  output logic [15:0] out_ethertype,
  output logic [15:0] out_length,
  output logic [15:0] drop_count
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
`ifdef RX_FRAME_PARSER_RUNT_FILTER_EN
  localparam bit RUNT_EN = 1'b1;
`else
  localparam bit RUNT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER,
    S_PAYLOAD, S_REPORT, S_DISCARD
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_length;
  logic [15:0] r_drops;
  logic [47:0] r_destin;
  logic [47:0] r_source;
  logic [15:0] r_type;
  logic        r_valid;

  logic [7:0]  w_byte;
  logic [15:0] w_len;
  logic [15:0] w_drop_inc;
  logic        w_last_hdr;
  logic        w_too_long;
  logic        w_runt;

  // MII delivers the low nibble first, so the assembler's byte is swapped
  assign w_byte     = {in_data[3:0], in_data[7:4]};
  assign w_len      = in_valid ? r_count + 16'd1 : r_count;
  assign w_drop_inc = (r_drops == 16'hFFFF) ? r_drops
                                            : r_drops + 16'd1;
  assign w_last_hdr = in_valid && (r_count == 16'd13);
  assign w_too_long = in_valid && (w_len > MAX_LEN);
  assign w_runt     = RUNT_EN && (w_len < MIN_LEN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_length <= '0;
      r_drops  <= '0;
      r_destin <= '0;
      r_source <= '0;
      r_type   <= '0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_frame) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (in_valid && in_data == 8'h5D) begin
            r_count <= '0;
            if (in_frame) begin
              r_state <= S_HEADER;
            end else begin
              r_state <= S_IDLE;
              r_drops <= w_drop_inc;
            end
          end else if (in_valid && in_data != 8'h55) begin
            r_drops <= w_drop_inc;
            r_state <= in_frame ? S_DISCARD : S_IDLE;
          end else if (!in_frame) begin
            r_state <= S_IDLE;
          end
        end
        S_HEADER: begin
          if (in_valid) begin
            r_count <= w_len;
            if (r_count < 16'd6)
              r_destin <= {r_destin[39:0], w_byte};
            else if (r_count < 16'd12)
              r_source <= {r_source[39:0], w_byte};
            else
              r_type <= {r_type[7:0], w_byte};
          end
          if (w_last_hdr && !in_frame) begin
            if (w_runt) begin
              r_state <= S_IDLE;
              r_drops <= w_drop_inc;
            end else begin
              r_state  <= S_REPORT;
              r_length <= w_len;
              r_valid  <= 1'b1;
            end
          end else if (w_last_hdr) begin
            r_state <= S_PAYLOAD;
          end else if (!in_frame) begin
            r_state <= S_IDLE;
            r_drops <= w_drop_inc;
          end
        end
        S_PAYLOAD: begin
          if (w_too_long) begin
            r_drops <= w_drop_inc;
            r_state <= in_frame ? S_DISCARD : S_IDLE;
          end else begin
            r_count <= w_len;
            if (!in_frame) begin
              if (w_runt) begin
                r_state <= S_IDLE;
                r_drops <= w_drop_inc;
              end else begin
                r_state  <= S_REPORT;
                r_length <= w_len;
                r_valid  <= 1'b1;
              end
            end
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            // a new frame began while the result waited: it is unusable
            if (in_frame) begin
              r_state <= S_DISCARD;
              r_drops <= w_drop_inc;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (!in_frame) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid      = r_valid;
  assign out_destin_mac = r_destin;
  assign out_source_mac = r_source;
  assign out_ethertype  = r_type;
  assign out_length     = r_length;
  assign drop_count     = r_drops;

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: random frames checked against a frame-level model.
// Model follows RX_FRAME_PARSER_RUNT_FILTER_EN like the design.
module tb_rx_frame_parser;

  localparam int MINB = 64;
  localparam int MAXB = 1518;
`ifdef RX_FRAME_PARSER_RUNT_FILTER_EN
  localparam bit RUNT = 1'b1;
`else
  localparam bit RUNT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_frame;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_destin_mac;
  logic [47:0] out_source_mac;
  logic [15:0] out_ethertype;
  logic [15:0] out_length;
  logic [15:0] drop_count;

  always #5 clock = ~clock;

  rx_frame_parser #(
    .MIN_FRAME_BYTES(MINB),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_frame(in_frame),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_destin_mac(out_destin_mac),
    .out_source_mac(out_source_mac),
    .out_ethertype(out_ethertype),
    .out_length(out_length),
    .drop_count(drop_count)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_drop = 0;
  logic [7:0] fb [0:2047];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int n, input bit hdr);
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    if (hdr) begin
      for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
      for (int i = 0; i < 6; i++) fb[6+i] = 8'(8'h11 * (i + 1));
      fb[12] = 8'h08;
      fb[13] = 8'h00;
    end
  endtask

  task automatic put(input logic [7:0] d, input bit gaps);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    if (gaps && $urandom_range(3) == 0) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input int npre, input bit bad, input int n,
                           input int stall, input bit ovl,
                           input bit gaps, input int abort);
    bit rep;
    logic [47:0] ed;
    logic [47:0] es;
    logic [15:0] et;
    rep = !bad && n >= 14 && n <= MAXB && !(RUNT && n < MINB);
    @(negedge clock);
    in_frame  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = (stall == 0);
    for (int i = 0; i < npre; i++) put(8'h55, gaps);
    if (bad) put(8'hAA, gaps);
    put(8'h5D, gaps);
    for (int i = 0; i < n; i++) begin
      if (i == abort) begin
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_dest", out_destin_mac, 0);
        chk("rst_len", out_length, 0);
        chk("rst_drop", drop_count, 0);
        @(negedge clock);
        reset = 1'b0;
        in_frame = 1'b0;
        return;
      end
      put({fb[i][3:0], fb[i][7:4]}, gaps);
    end
    @(negedge clock);
    in_frame = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("valid_rise", out_valid, rep);
    if (rep) begin
      ed = '0;
      es = '0;
      for (int i = 0; i < 6; i++) ed = {ed[39:0], fb[i]};
      for (int i = 6; i < 12; i++) es = {es[39:0], fb[i]};
      et = {fb[12], fb[13]};
      chk("dest", out_destin_mac, ed);
      chk("src", out_source_mac, es);
      chk("type", out_ethertype, et);
      chk("len", out_length, n);
      if (stall > 0) begin
        repeat (stall) @(negedge clock);
        chk("valid_held", out_valid, 1);
        chk("dest_held", out_destin_mac, ed);
        chk("src_held", out_source_mac, es);
        chk("len_held", out_length, n);
        out_ready = 1'b1;
        in_frame  = ovl;
      end
      @(negedge clock);
      chk("valid_clear", out_valid, 0);
      out_ready = 1'b0;
      if (stall > 0 && ovl) begin
        exp_drop++;
        in_frame = 1'b0;
        @(negedge clock);
      end
    end else begin
      exp_drop++;
    end
    chk("drop", drop_count, exp_drop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int st;
    bit bd;
    in_data   = '0;
    in_valid  = 1'b0;
    in_frame  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_valid", out_valid, 0);
    chk("reset_dest", out_destin_mac, 0);
    chk("reset_src", out_source_mac, 0);
    chk("reset_type", out_ethertype, 0);
    chk("reset_len", out_length, 0);
    chk("reset_drop", drop_count, 0);
    reset = 1'b0;

    fill(64, 1'b1);
    run_frame(7, 1'b0, 64, 0, 1'b0, 1'b0, 30);
    fill(64, 1'b1);
    run_frame(7, 1'b0, 64, 0, 1'b0, 1'b0, -1);
    fill(64, 1'b1);
    run_frame(7, 1'b0, 64, 10, 1'b0, 1'b0, -1);
    fill(64, 1'b0);
    run_frame(7, 1'b1, 64, 0, 1'b0, 1'b0, -1);
    fill(1519, 1'b0);
    run_frame(7, 1'b0, 1519, 0, 1'b0, 1'b0, -1);
    fill(1518, 1'b0);
    run_frame(7, 1'b0, 1518, 2, 1'b0, 1'b1, -1);
    fill(40, 1'b0);
    run_frame(7, 1'b0, 40, 0, 1'b0, 1'b0, -1);
    fill(10, 1'b0);
    run_frame(7, 1'b0, 10, 0, 1'b0, 1'b0, -1);
    fill(14, 1'b0);
    run_frame(2, 1'b0, 14, 1, 1'b0, 1'b0, -1);
    fill(13, 1'b0);
    run_frame(2, 1'b0, 13, 0, 1'b0, 1'b0, -1);
    fill(64, 1'b0);
    run_frame(3, 1'b0, 64, 3, 1'b1, 1'b0, -1);

    for (int k = 0; k < 25; k++) begin
      n  = $urandom_range(120, 0);
      bd = ($urandom_range(7) == 0);
      st = $urandom_range(4, 0);
      fill(n, 1'b0);
      run_frame($urandom_range(7, 1), bd, n, st,
                (st > 0) && ($urandom_range(4) == 0),
                1'($urandom_range(1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
